// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster timing generator with renderer-latency-aligned sync and colour
module vga_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 4,
   parameter int PIPE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] rgb_in,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        pix_de,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // One spare code so the sync-end bound still fits when the back porch is empty.
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   // Tick divider
   logic [DW-1:0] div_q, div_d;
   logic          pe;

   // Raster counters
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          h_wrap, v_wrap;

   // Raw decode of the tick currently ending
   logic          act_raw, hs_raw, vs_raw;

   // Latency-matching delay lines, bit 0 is the youngest stage
   logic [PIPE_LAT-1:0] act_sr_q, act_sr_d;
   logic [PIPE_LAT-1:0] hs_sr_q,  hs_sr_d;
   logic [PIPE_LAT-1:0] vs_sr_q,  vs_sr_d;

   // Output registers
   logic [9:0]  pix_x_q, pix_x_d;
   logic [8:0]  pix_y_q, pix_y_d;
   logic [11:0] rgb_q,   rgb_d;
   logic        fs_q,    fs_d;

   // Pixel-tick divider: pe marks the last clk of each tick and the count restarts there.
   always_comb begin
      pe    = (div_q == DIV_LAST);
      div_d = pe ? '0 : div_q + DW'(1);
   end

   // Raster counters advance on pe; the line counter steps only on the column wrap.
   always_comb begin
      h_wrap = (h_q == H_LAST);
      v_wrap = (v_q == V_LAST);
      h_d    = h_q;
      v_d    = v_q;
      if (pe) begin
         h_d = h_wrap ? '0 : h_q + HW'(1);
         if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + VW'(1);
         end
      end
   end

   // Active-area and sync decode for the tick whose pe is now occurring.
   always_comb begin
      act_raw = (h_q < H_ACT_END) && (v_q < V_ACT_END);
      hs_raw  = !((h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END));
      vs_raw  = !((v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END));
   end

   // Delay lines shift on pe; the oldest stage drives the pins so sync lines up with colour.
   always_comb begin
      act_sr_d = act_sr_q;
      hs_sr_d  = hs_sr_q;
      vs_sr_d  = vs_sr_q;
      if (pe) begin
         act_sr_d = PIPE_LAT'({act_sr_q, act_raw});
         hs_sr_d  = PIPE_LAT'({hs_sr_q, hs_raw});
         vs_sr_d  = PIPE_LAT'({vs_sr_q, vs_raw});
      end
   end

   // Coordinates take the counters' next value so they describe the tick being entered.
   always_comb begin
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      if (pe) begin
         pix_x_d = (h_d < H_ACT_END) ? 10'(h_d) : '0;
         pix_y_d = (v_d < V_ACT_END) ? 9'(v_d) : '0;
      end
   end

   // Colour capture, forced black when the pixel entering the last stage is blanking.
   always_comb begin
      rgb_d = rgb_q;
      if (pe) begin
         rgb_d = act_sr_d[PIPE_LAT-1] ? rgb_in : 12'h000;
      end
   end

   // Frame pulse is high only in the clk after the counters wrap back to the origin.
   always_comb begin
      fs_d = pe & h_wrap & v_wrap;
   end

   // Divider and raster counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   // Delay lines reset to an idle, blanked, sync-inactive raster.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_sr_q <= '0;
         hs_sr_q  <= '1;
         vs_sr_q  <= '1;
      end else begin
         act_sr_q <= act_sr_d;
         hs_sr_q  <= hs_sr_d;
         vs_sr_q  <= vs_sr_d;
      end
   end

   // Coordinate, colour and frame-pulse output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_x_q <= '0;
         pix_y_q <= '0;
         rgb_q   <= '0;
         fs_q    <= 1'b0;
      end else begin
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
         rgb_q   <= rgb_d;
         fs_q    <= fs_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign hsync       = hs_sr_q[PIPE_LAT-1];
   assign vsync       = vs_sr_q[PIPE_LAT-1];
   assign pix_de      = act_sr_q[PIPE_LAT-1];
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign frame_start = fs_q;

endmodule
